// File: rtl/fp_pkg.sv
// ---------------------------------------------------------------------------
// fp_pkg: shared constants for the sequential single-precision adder.
//   - word / exponent / mantissa widths
//   - IEEE-754 special encodings (bias, max exponent, quiet NaN, +Inf)
//   - 3-bit state encoding of the adder control FSM
// ---------------------------------------------------------------------------
package fp_pkg;

    localparam int W        = 32;
    localparam int EW       = 8;
    localparam int MW       = 23;

    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CMP   = 3'd1;
    localparam logic [2:0] ALIGN = 3'd2;
    localparam logic [2:0] ADD   = 3'd3;
    localparam logic [2:0] NORM  = 3'd4;
    localparam logic [2:0] PACK  = 3'd5;
    localparam logic [2:0] DONE  = 3'd6;

endpackage

// File: rtl/fp_add_subt_lzc.sv
// ---------------------------------------------------------------------------
// fp_lzc: combinational leading-zero counter.
//   value : DW-bit vector, MSB first
//   count : number of zeros above the most significant 1 (DW when all zero)
// ---------------------------------------------------------------------------
module fp_lzc #(
    parameter int DW = fp_pkg::MW + 5,
    parameter int CW = 5
) (
    input  logic [DW-1:0] value,
    output logic [CW-1:0] count
);

    // Ascending scan: the last hit is the most significant set bit.
    always_comb begin
        count = CW'(DW);
        for (int i = 0; i < DW; i++) begin
            if (value[i]) count = CW'(DW - 1 - i);
        end
    end

endmodule

// File: rtl/fp_add_subt_seq.sv
// ---------------------------------------------------------------------------
// fp_add_subt_seq: multi-cycle IEEE-754 single-precision adder/subtractor,
// responder side of the Begin_SUM / ACK_ADD_SUBT handshake.
//   CLK, RST_N     : clock, asynchronous active-low reset
//   Begin_SUM      : start request, accepted in IDLE or DONE only
//   ADD_SUBT       : 0 = A+B, 1 = A-B (captured with Begin_SUM)
//   Dato_A, Dato_B : operands (captured with Begin_SUM)
//   ACK_ADD_SUBT   : result valid level, held until the next accepted start
//   RESULT         : registered sum/difference, round-to-nearest-even
//   OVERFLOW       : result saturated to +/-Inf
//   UNDERFLOW      : result flushed to zero by exponent underflow
// ---------------------------------------------------------------------------
module fp_add_subt_seq #(
    parameter int W  = fp_pkg::W,
    parameter int EW = fp_pkg::EW,
    parameter int MW = fp_pkg::MW
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         Begin_SUM,
    input  logic         ADD_SUBT,
    input  logic [W-1:0] Dato_A,
    input  logic [W-1:0] Dato_B,
    output logic         ACK_ADD_SUBT,
    output logic [W-1:0] RESULT,
    output logic         OVERFLOW,
    output logic         UNDERFLOW
);

    import fp_pkg::*;

    // Aligned operand: hidden + MW + guard/round/sticky; the sum adds a carry.
    localparam int AW = MW + 4;
    localparam int DW = MW + 5;
    localparam int XW = EW + 2;   // signed exponent with head-room both ways

    // ---------------- control FSM ----------------
    logic [2:0] state, state_nx;
    logic       load_op, pack_en;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves state_nx unassigned
        // and a latch is never inferred.
        state_nx = state;
        case (state)
            IDLE:    if (Begin_SUM) state_nx = CMP;
            CMP:     state_nx = ALIGN;
            ALIGN:   state_nx = ADD;
            ADD:     state_nx = NORM;
            NORM:    state_nx = PACK;
            PACK:    state_nx = DONE;
            DONE:    if (Begin_SUM) state_nx = CMP;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        load_op = ((state == IDLE) || (state == DONE)) && Begin_SUM;
        pack_en = (state == PACK);
    end

    // ---------------- operand capture ----------------
    logic [W-1:0] a_q, b_q;
    logic         op_q;

    // NOTE: every datapath register is reset (not just control) so an aborted
    // operation leaves no partial state behind.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            a_q <= '0; b_q <= '0; op_q <= 1'b0;
        end else if (load_op) begin
            a_q <= Dato_A; b_q <= Dato_B; op_q <= ADD_SUBT;
        end
    end

    // ---------------- CMP: unpack, swap, special detect ----------------
    logic [EW-1:0] ea, eb;
    logic [MW:0]   ma, mb;
    logic [W-2:0]  mag_a, mag_b;
    logic          sa, sb, inf_a, inf_b, swap;
    logic [W-1:0]  spec_c;

    always_comb begin
        ea    = a_q[W-2:MW];
        eb    = b_q[W-2:MW];
        // Exponent 0 is +/-0: denormal mantissas are discarded.
        ma    = (ea == '0) ? '0 : {1'b1, a_q[MW-1:0]};
        mb    = (eb == '0) ? '0 : {1'b1, b_q[MW-1:0]};
        mag_a = (ea == '0) ? '0 : a_q[W-2:0];
        mag_b = (eb == '0) ? '0 : b_q[W-2:0];
        sa    = a_q[W-1];
        sb    = b_q[W-1] ^ op_q;
        inf_a = &ea;
        inf_b = &eb;
        swap  = mag_b > mag_a;
        if (inf_a && inf_b)
            spec_c = (sa == sb) ? (POS_INF | {sa, {(W-1){1'b0}}}) : QNAN;
        else if (inf_a)
            spec_c = POS_INF | {sa, {(W-1){1'b0}}};
        else
            spec_c = POS_INF | {sb, {(W-1){1'b0}}};
    end

    logic          sx_q, sy_q, spec_q;
    logic [EW-1:0] ex_q, d_q;
    logic [MW:0]   mx_q, my_q;
    logic [W-1:0]  spec_res_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sx_q <= 1'b0; sy_q <= 1'b0; ex_q <= '0; d_q <= '0;
            mx_q <= '0; my_q <= '0; spec_q <= 1'b0; spec_res_q <= '0;
        end else if (state == CMP) begin
            sx_q       <= swap ? sb : sa;
            sy_q       <= swap ? sa : sb;
            ex_q       <= swap ? eb : ea;
            d_q        <= swap ? (eb - ea) : (ea - eb);
            mx_q       <= swap ? mb : ma;
            my_q       <= swap ? ma : mb;
            spec_q     <= inf_a || inf_b;
            spec_res_q <= spec_c;
        end
    end

    // ---------------- ALIGN: shift Y right, keep G/R/S ----------------
    logic [AW-1:0] y_ext, y_shr, lost_mask, y_al;

    always_comb begin
        y_ext     = {my_q, 3'b000};
        y_shr     = y_ext >> d_q;
        lost_mask = ~({AW{1'b1}} << d_q);
        if (d_q >= EW'(MW + 3))
            y_al = {{(AW-1){1'b0}}, |my_q};
        else
            y_al = {y_shr[AW-1:1], y_shr[0] | (|(y_ext & lost_mask))};
    end

    logic [AW-1:0] xa_q, ya_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            xa_q <= '0; ya_q <= '0;
        end else if (state == ALIGN) begin
            xa_q <= {mx_q, 3'b000};
            ya_q <= y_al;
        end
    end

    // ---------------- ADD: magnitude add / subtract ----------------
    // X >= Y in magnitude, so the difference never goes negative.
    logic [DW-1:0] sum_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)              sum_q <= '0;
        else if (state == ADD)   sum_q <= (sx_q ^ sy_q) ? ({1'b0, xa_q} - {1'b0, ya_q})
                                                        : ({1'b0, xa_q} + {1'b0, ya_q});
    end

    // ---------------- NORM ----------------
    logic [4:0]          lz, shamt;
    logic [DW-1:0]       n_c;
    logic signed [XW-1:0] ex_ext, e_c;
    logic                zero_c, uf_c;

    fp_lzc #(.DW(DW), .CW(5)) u_lzc (
        .value (sum_q),
        .count (lz)
    );

    always_comb begin
        // The hidden bit belongs one below the carry, so shift by lz-1.
        shamt  = lz - 5'd1;
        ex_ext = $signed({2'b00, ex_q});
        zero_c = ~|sum_q;
        if (sum_q[DW-1]) begin
            n_c = {1'b0, sum_q[DW-1:2], |sum_q[1:0]};
            e_c = ex_ext + XW'(1);
        end else begin
            n_c = sum_q << shamt;
            e_c = ex_ext - $signed({{(XW-5){1'b0}}, shamt});
        end
        uf_c = !zero_c && (e_c <= 0);
    end

    logic [DW-1:0]        n_q;
    logic signed [XW-1:0] ne_q;
    logic                 zero_q, uf_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            n_q <= '0; ne_q <= '0; zero_q <= 1'b0; uf_q <= 1'b0;
        end else if (state == NORM) begin
            n_q <= n_c; ne_q <= e_c; zero_q <= zero_c; uf_q <= uf_c;
        end
    end

    // ---------------- PACK: round, saturate, special bypass ----------------
    logic                 rnd;
    logic [MW+1:0]        m_rnd;
    logic signed [XW-1:0] e_fin;
    logic [W-1:0]         res_c;
    logic                 ovf_c, udf_c;

    always_comb begin
        rnd   = n_q[2] & (n_q[1] | n_q[0] | n_q[3]);
        m_rnd = {1'b0, n_q[DW-2:3]} + (MW+2)'(rnd);
        e_fin = m_rnd[MW+1] ? (ne_q + XW'(1)) : ne_q;
        ovf_c = 1'b0;
        udf_c = 1'b0;
        if (spec_q) begin
            res_c = spec_res_q;
        end else if (zero_q) begin
            res_c = '0;               // exact cancellation is always +0
        end else if (uf_q) begin
            res_c = {sx_q, {(W-1){1'b0}}};
            udf_c = 1'b1;
        end else if (e_fin >= EXP_MAX) begin
            res_c = POS_INF | {sx_q, {(W-1){1'b0}}};
            ovf_c = 1'b1;
        end else begin
            res_c = {sx_q, e_fin[EW-1:0], m_rnd[MW-1:0]};
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            RESULT <= '0; OVERFLOW <= 1'b0; UNDERFLOW <= 1'b0; ACK_ADD_SUBT <= 1'b0;
        end else begin
            if (pack_en) begin
                RESULT    <= res_c;
                OVERFLOW  <= ovf_c;
                UNDERFLOW <= udf_c;
            end
            if (load_op)      ACK_ADD_SUBT <= 1'b0;
            else if (pack_en) ACK_ADD_SUBT <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fp_add_subt_seq.sv
// ---------------------------------------------------------------------------
// tb_fp_add_subt_seq: scoreboard-driven bench for fp_add_subt_seq.
// Expected results are pushed when a request is issued and popped when the
// DUT raises ACK_ADD_SUBT.
// ---------------------------------------------------------------------------
module tb_fp_add_subt_seq;

    import fp_pkg::*;

    logic        CLK, RST_N, Begin_SUM, ADD_SUBT;
    logic [31:0] Dato_A, Dato_B, RESULT;
    logic        ACK_ADD_SUBT, OVERFLOW, UNDERFLOW;

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
        logic        udf;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    fp_add_subt_seq dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .Begin_SUM    (Begin_SUM),
        .ADD_SUBT     (ADD_SUBT),
        .Dato_A       (Dato_A),
        .Dato_B       (Dato_B),
        .ACK_ADD_SUBT (ACK_ADD_SUBT),
        .RESULT       (RESULT),
        .OVERFLOW     (OVERFLOW),
        .UNDERFLOW    (UNDERFLOW)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Drive one request across a sampling edge; return ACK seen 1 ns later.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic op,
                        input exp_t e, output logic ack_after);
        @(negedge CLK);
        Dato_A = a; Dato_B = b; ADD_SUBT = op; Begin_SUM = 1'b1;
        sb_q.push_back(e);
        @(posedge CLK); #1;
        Begin_SUM = 1'b0;
        ack_after = ACK_ADD_SUBT;
    endtask

    // Count edges until ACK is seen (bounded).
    task automatic wait_ack(output int lat);
        lat = 0;
        while (!ACK_ADD_SUBT && lat < 20) begin
            @(posedge CLK); #1;
            lat++;
        end
    endtask

    // Issue one operation and compare it against the scoreboard.
    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic op, input logic [31:0] res, input logic ovf,
                          input logic udf);
        exp_t e;
        logic ack0;
        int   lat;
        e.res = res; e.ovf = ovf; e.udf = udf;
        send(a, b, op, e, ack0);
        n_cmp++;
        if (ack0 !== 1'b0) begin
            n_bad++;
            $display("FAIL %s ack_after_issue: got %b, required 0", name, ack0);
        end
        wait_ack(lat);
        n_cmp++;
        if (lat != 5) begin
            n_bad++;
            $display("FAIL %s latency: got %0d edges, required 5", name, lat);
        end
        e = sb_q.pop_front();
        n_cmp++;
        if (RESULT !== e.res) begin
            n_bad++;
            $display("FAIL %s result: got %h, required %h", name, RESULT, e.res);
        end
        n_cmp++;
        if ({OVERFLOW, UNDERFLOW} !== {e.ovf, e.udf}) begin
            n_bad++;
            $display("FAIL %s flags: got ovf=%b udf=%b, required ovf=%b udf=%b",
                     name, OVERFLOW, UNDERFLOW, e.ovf, e.udf);
        end
    endtask

    task automatic test_reset;
        RST_N = 1'b0; Begin_SUM = 1'b0; ADD_SUBT = 1'b0; Dato_A = '0; Dato_B = '0;
        repeat (2) @(posedge CLK);
        #1;
        n_cmp++;
        if ({RESULT, ACK_ADD_SUBT, OVERFLOW, UNDERFLOW} !== 35'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got RESULT=%h ACK=%b OVF=%b UDF=%b, required all 0",
                     RESULT, ACK_ADD_SUBT, OVERFLOW, UNDERFLOW);
        end
        n_cmp++;
        if (dut.state !== IDLE) begin
            n_bad++;
            $display("FAIL reset_state: got %0d, required %0d", dut.state, IDLE);
        end
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic test_basic_add;
        run_op("add_1p0_2p0", 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 1'b0, 1'b0);
    endtask

    task automatic test_subtract;
        run_op("sub_norm",   32'h3FC0_0000, 32'h3FA0_0000, 1'b1, 32'h3E80_0000, 1'b0, 1'b0);
        run_op("sub_cancel", 32'h4040_0000, 32'h4040_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b0);
    endtask

    task automatic test_rounding;
        run_op("round_tie",   32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, 1'b0, 1'b0);
        run_op("round_above", 32'h3F80_0000, 32'h33C0_0000, 1'b0, 32'h3F80_0001, 1'b0, 1'b0);
    endtask

    task automatic test_special;
        run_op("overflow",     32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 1'b1, 1'b0);
        run_op("inf_minus_inf", 32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000, 1'b0, 1'b0);
    endtask

    // A second Begin_SUM while in ALIGN must not disturb the in-flight op.
    task automatic test_ignore_in_align;
        exp_t e;
        logic ack0;
        int   lat;
        e.res = 32'h4080_0000; e.ovf = 1'b0; e.udf = 1'b0;   // 3.0 + 1.0
        send(32'h4040_0000, 32'h3F80_0000, 1'b0, e, ack0);
        @(posedge CLK); #1;                                  // now in ALIGN
        @(negedge CLK);
        Dato_A = 32'h3F80_0000; Dato_B = 32'h3F80_0000; Begin_SUM = 1'b1;
        @(posedge CLK); #1;
        Begin_SUM = 1'b0;
        wait_ack(lat);
        n_cmp++;
        if (lat != 3) begin
            n_bad++;
            $display("FAIL ignore_latency: got %0d more edges, required 3", lat);
        end
        e = sb_q.pop_front();
        n_cmp++;
        if (RESULT !== e.res) begin
            n_bad++;
            $display("FAIL ignore_result: got %h, required %h", RESULT, e.res);
        end
        repeat (6) @(posedge CLK);
        #1;
        n_cmp++;
        if (ACK_ADD_SUBT !== 1'b1 || RESULT !== e.res) begin
            n_bad++;
            $display("FAIL ack_hold: got ACK=%b RESULT=%h, required ACK=1 RESULT=%h",
                     ACK_ADD_SUBT, RESULT, e.res);
        end
    endtask

    // Issued straight from DONE: ACK drops on the accepting edge.
    task automatic test_back_to_back;
        run_op("b2b_first",  32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 1'b0, 1'b0);
        run_op("b2b_second", 32'h4000_0000, 32'h3F80_0000, 1'b1, 32'h3F80_0000, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_op;
        exp_t e;
        logic ack0;
        e.res = 32'h4040_0000; e.ovf = 1'b0; e.udf = 1'b0;
        send(32'h3F80_0000, 32'h4000_0000, 1'b0, e, ack0);
        repeat (2) @(posedge CLK);
        #1;
        n_cmp++;
        if (dut.state !== ADD) begin
            n_bad++;
            $display("FAIL mid_op_state: got %0d, required %0d", dut.state, ADD);
        end
        RST_N = 1'b0;
        #1;
        void'(sb_q.pop_back());                              // aborted, no result
        n_cmp++;
        if (RESULT !== 32'h0 || ACK_ADD_SUBT !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: got RESULT=%h ACK=%b, required 00000000/0",
                     RESULT, ACK_ADD_SUBT);
        end
        n_cmp++;
        if (dut.state !== IDLE) begin
            n_bad++;
            $display("FAIL async_reset_state: got %0d, required %0d", dut.state, IDLE);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        run_op("after_reset", 32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_subtract();
        test_rounding();
        test_special();
        test_ignore_in_align();
        test_back_to_back();
        test_reset_mid_op();
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
